uart_ack_responder: RTL and testbench

//  Sits at the receive end of the UART link and answers every received frame on its own

---
 rtl/uart_ack_responder.sv | 176 +++++++++++++++++
 tb/tb_uart_ack_responder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_ack_responder.sv
// rtl/uart_ack_responder.sv - per-frame ACK/NAK responder on a return UART line
// Serializes ACK_CODE or NAK_CODE as start, LSB-first payload, even parity, stop; one pending slot.
module uart_ack_responder #(
  parameter int                    CLK_FREQ   = 50_000_000,
  parameter int                    BAUD_RATE  = 115_200,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] ACK_CODE   = 'h06,
  parameter logic [DATA_WIDTH-1:0] NAK_CODE   = 'h15,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_valid,
  input  logic                 rx_parity_err,
  output logic                 tx,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] ack_count,
  output logic [CNT_WIDTH-1:0] nak_count,
  output logic                 overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_q, par_d;
  logic                    slot_q, slot_d;
  logic                    slot_err_q, slot_err_d;
  logic [CNT_WIDTH-1:0]    ack_q, ack_d;
  logic [CNT_WIDTH-1:0]    nak_q, nak_d;
  logic                    overrun_q, overrun_d;
  logic                    tx_q, tx_d;
  logic                    bit_end;
  logic                    stop_done;
  logic                    launch;
  logic                    launch_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      slot_q     <= 1'b0;
      slot_err_q <= 1'b0;
      ack_q      <= '0;
      nak_q      <= '0;
      overrun_q  <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      par_q      <= par_d;
      slot_q     <= slot_d;
      slot_err_q <= slot_err_d;
      ack_q      <= ack_d;
      nak_q      <= nak_d;
      overrun_q  <= overrun_d;
      tx_q       <= tx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + 1'b1;
    idx_d      = idx_q;
    data_d     = data_q;
    par_d      = par_q;
    slot_d     = slot_q;
    slot_err_d = slot_err_q;
    ack_d      = ack_q;
    nak_d      = nak_q;
    overrun_d  = 1'b0;
    launch     = 1'b0;
    launch_err = 1'b0;
    tx_d       = 1'b1;
    bit_end    = (baud_q == BAUD_LAST);
    stop_done  = (state_q == S_STOP) && bit_end;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (rx_valid) begin
          launch     = 1'b1;
          launch_err = rx_parity_err;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        baud_d  = '0;
        idx_d   = '0;
      end
      S_DATA: if (bit_end) begin
        baud_d = '0;
        if (idx_q == IDX_LAST) state_d = S_PARITY;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        baud_d  = '0;
      end
      S_STOP: if (bit_end) begin
        // A queued frame goes first; a coincident new request then takes the freed slot.
        if (slot_q) begin
          launch     = 1'b1;
          launch_err = slot_err_q;
          slot_d     = rx_valid;
          slot_err_d = rx_valid ? rx_parity_err : 1'b0;
        end else if (rx_valid) begin
          launch     = 1'b1;
          launch_err = rx_parity_err;
        end else begin
          state_d = S_IDLE;
          baud_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    if (state_q != S_IDLE && !stop_done && rx_valid) begin
      if (!slot_q) begin
        slot_d     = 1'b1;
        slot_err_d = rx_parity_err;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (launch) begin
      state_d = S_START;
      baud_d  = '0;
      idx_d   = '0;
      data_d  = launch_err ? NAK_CODE : ACK_CODE;
      par_d   = ^data_d;
      if (launch_err) begin
        if (nak_q != CNT_MAX) nak_d = nak_q + 1'b1;
      end else begin
        if (ack_q != CNT_MAX) ack_d = ack_q + 1'b1;
      end
    end

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[idx_d];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE);
  assign ack_count = ack_q;
  assign nak_count = nak_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_ack_responder.sv
// tb/tb_uart_ack_responder.sv - scoreboard bench for uart_ack_responder
module tb_uart_ack_responder;

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_parity_err = 1'b0;
  logic        tx, busy, overrun;
  logic [15:0] ack_count, nak_count;
  logic        tx2, busy2, overrun2;
  logic [1:0]  ack2, nak2;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];

  uart_ack_responder #(.CLK_FREQ(1000), .BAUD_RATE(100), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .tx(tx), .busy(busy), .ack_count(ack_count), .nak_count(nak_count), .overrun(overrun)
  );

  uart_ack_responder #(.CLK_FREQ(1000), .BAUD_RATE(100), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_parity_err(rx_parity_err),
    .tx(tx2), .busy(busy2), .ack_count(ack2), .nak_count(nak2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic err);
    rx_valid      = 1'b1;
    rx_parity_err = err;
    @(negedge clk);
    rx_valid      = 1'b0;
    rx_parity_err = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int exp_len);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, exp_len);
  endtask

  task automatic hold_idle(input string tag, input int cycles);
    logic ok = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    check(tag, ok, 1);
  endtask

  // Frame monitor: samples every cycle of a frame, pops the expected code at the start bit.
  initial begin
    int          k;
    int          b;
    logic        active = 1'b0;
    logic        stable;
    logic [10:0] obs;
    logic [10:0] expf;
    logic [7:0]  code;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 1'b0;
      end else begin
        if (!active && tx === 1'b0) begin
          active = 1'b1;
          k      = 0;
          stable = 1'b1;
          obs    = '0;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_frame", 1, 0);
            expf = '0;
          end else begin
            code = exp_q.pop_front();
            expf = {1'b1, ^code, code, 1'b0};
          end
        end
        if (active) begin
          b = k / 10;
          if (k % 10 == 0) obs[b] = tx;
          else if (tx !== obs[b]) stable = 1'b0;
          k++;
          if (k == 110) begin
            check("frame_bits", obs, expf);
            check("frame_bit_timing", stable, 1);
            active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ack", ack_count, 0);
    check("rst_nak", nak_count, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    hold_idle("idle_tx_high", 200);

    exp_q.push_back(ACK);
    pulse(1'b0);
    check("ack_tx_start", tx, 0);
    check("ack_busy", busy, 1);
    check("ack_count_1", ack_count, 1);
    wait_idle("ack_frame_len", 110);
    repeat (3) @(negedge clk);

    exp_q.push_back(NAK);
    pulse(1'b1);
    check("nak_count_1", nak_count, 1);
    check("nak_ack_unchanged", ack_count, 1);
    wait_idle("nak_frame_len", 110);
    repeat (3) @(negedge clk);

    exp_q.push_back(ACK);
    pulse(1'b0);
    repeat (19) @(negedge clk);
    exp_q.push_back(NAK);
    pulse(1'b1);
    check("queued_no_overrun", overrun, 0);
    repeat (19) @(negedge clk);
    pulse(1'b0);
    check("dropped_overrun", overrun, 1);
    check("dropped_ack_mid", ack_count, 2);
    @(negedge clk);
    check("overrun_one_cycle", overrun, 0);
    wait_idle("back_to_back_len", 179);
    check("b2b_ack_total", ack_count, 2);
    check("b2b_nak_total", nak_count, 2);
    repeat (2) @(negedge clk);

    exp_q.push_back(ACK);
    pulse(1'b0);
    repeat (9) @(negedge clk);
    pulse(1'b1);
    repeat (44) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ack", ack_count, 0);
    check("midrst_nak", nak_count, 0);
    check("midrst_sat_ack", ack2, 0);
    rst_n = 1'b1;
    hold_idle("midrst_no_resume", 150);

    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(ACK);
      pulse(1'b0);
      check("sat_ack_wide", ack_count, i);
      check("sat_ack_narrow", ack2, (i < 3) ? i : 3);
      wait_idle("sat_frame_len", 110);
      @(negedge clk);
    end
    check("sat_nak_narrow", nak2, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
